// File: rtl/sobel_pkg.sv
// Constants and helpers shared between the window generator and the Sobel core.
package sobel_pkg;

  localparam int PIX_W          = 8;
  localparam int IMG_WIDTH_DEF  = 64;
  localparam int IMG_HEIGHT_DEF = 48;
  localparam int WIN_N          = 9;

  // Element (r,c) of a 3x3 window occupies slot 3r+c of the packed window bus.
  function automatic int win_idx(input int r, input int c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One-row delay line: a DEPTH-1 entry read-before-write RAM plus its read
// register, so rd_data_o is the sample written exactly DEPTH accepts earlier.
module sobel_line_buffer #(
  parameter int DEPTH = 64,
  parameter int DW    = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          en_i,
  input  logic [DW-1:0] wr_data_i,
  output logic [DW-1:0] rd_data_o
);

  localparam int RD = DEPTH - 1;
  localparam int AW = (RD > 1) ? $clog2(RD) : 1;

  logic [DW-1:0] mem_q [RD];
  logic [AW-1:0] ptr_q, ptr_d;
  logic [DW-1:0] rd_q;

  // Pointer advance, wrapping over the RAM depth.
  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      if (ptr_q == AW'(RD - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + AW'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // RAM write port; contents are intentionally not reset.
  always_ff @(posedge clock) begin
    if (en_i) begin
      mem_q[ptr_q] <= wr_data_i;
    end
  end

  // Read register captures the old word at the address being overwritten.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
      rd_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (en_i) begin
        rd_q <= mem_q[ptr_q];
      end
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a two-column shift
// register feed a 1-deep output register holding only fully-inside windows.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int PIX_W      = sobel_pkg::PIX_W,
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1,
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIX_W-1:0]   in_data,
  input  logic               in_sof,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [9*PIX_W-1:0] win_data,
  output logic [CW-1:0]      win_col,
  output logic [RW-1:0]      win_row,
  output logic               frame_done
);

  logic [CW-1:0]            col_q, col_d, cur_col_s;
  logic [RW-1:0]            row_q, row_d, cur_row_s;
  logic                     out_valid_q, out_valid_d;
  logic [9*PIX_W-1:0]       win_data_q, win_data_d, win_s;
  logic [CW-1:0]            win_col_q, win_col_d;
  logic [RW-1:0]            win_row_q, win_row_d;
  logic                     frame_done_q, frame_done_d;
  logic [2:0][PIX_W-1:0]    col0_q, col0_d, col1_q, col1_d, new_col_s;
  logic [PIX_W-1:0]         line0_s, line1_s;
  logic                     accept_s, last_col_s, last_row_s, win_ok_s;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept_s  = in_valid && in_ready;

  // sof overrides the raster counters for the pixel it qualifies.
  assign cur_col_s  = in_sof ? '0 : col_q;
  assign cur_row_s  = in_sof ? '0 : row_q;
  assign last_col_s = (cur_col_s == CW'(IMG_WIDTH - 1));
  assign last_row_s = (cur_row_s == RW'(IMG_HEIGHT - 1));
  assign win_ok_s   = (cur_row_s >= RW'(2)) && (cur_col_s >= CW'(2));

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .DW(PIX_W)) u_line0 (
    .clock     (clock),
    .reset_n   (reset_n),
    .en_i      (accept_s),
    .wr_data_i (in_data),
    .rd_data_o (line0_s)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .DW(PIX_W)) u_line1 (
    .clock     (clock),
    .reset_n   (reset_n),
    .en_i      (accept_s),
    .wr_data_i (line0_s),
    .rd_data_o (line1_s)
  );

  assign new_col_s[0] = line1_s;
  assign new_col_s[1] = line0_s;
  assign new_col_s[2] = in_data;

  // Assemble the candidate window from the two stored columns and the new one.
  always_comb begin
    win_s = '0;
    for (int r = 0; r < 3; r++) begin
      win_s[PIX_W*win_idx(r, 0) +: PIX_W] = col0_q[r];
      win_s[PIX_W*win_idx(r, 1) +: PIX_W] = col1_q[r];
      win_s[PIX_W*win_idx(r, 2) +: PIX_W] = new_col_s[r];
    end
  end

  // Next-state for counters, column shift register and output register.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    col0_d       = col0_q;
    col1_d       = col1_q;
    frame_done_d = 1'b0;
    out_valid_d  = out_valid_q;
    win_data_d   = win_data_q;
    win_col_d    = win_col_q;
    win_row_d    = win_row_q;

    if (accept_s) begin
      col0_d       = col1_q;
      col1_d       = new_col_s;
      frame_done_d = last_col_s && last_row_s;
      if (last_col_s) begin
        col_d = '0;
        row_d = last_row_s ? '0 : (cur_row_s + RW'(1));
      end else begin
        col_d = cur_col_s + CW'(1);
        row_d = cur_row_s;
      end
    end else begin
      frame_done_d = 1'b0;
    end

    if (accept_s && win_ok_s) begin
      out_valid_d = 1'b1;
      win_data_d  = win_s;
      win_col_d   = cur_col_s;
      win_row_d   = cur_row_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_q        <= '0;
      row_q        <= '0;
      col0_q       <= '0;
      col1_q       <= '0;
      out_valid_q  <= 1'b0;
      win_data_q   <= '0;
      win_col_q    <= '0;
      win_row_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      col0_q       <= col0_d;
      col1_q       <= col1_d;
      out_valid_q  <= out_valid_d;
      win_data_q   <= win_data_d;
      win_col_q    <= win_col_d;
      win_row_q    <= win_row_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign win_data   = win_data_q;
  assign win_col    = win_col_q;
  assign win_row    = win_row_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 4x4 frame with pixel = 4*row+col.
module tb_sobel_window_gen;

  localparam int W = 4;
  localparam int H = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'd0;
  logic        in_sof = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [71:0] win_data;
  logic [1:0]  win_col;
  logic [1:0]  win_row;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  int fd_cnt = 0;

  logic [71:0] wq[$];
  logic [1:0]  rq[$];
  logic [1:0]  cq[$];

  logic [71:0] exp_win [4];
  logic [1:0]  exp_row [4];
  logic [1:0]  exp_col [4];

  sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sof     (in_sof),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .win_data   (win_data),
    .win_col    (win_col),
    .win_row    (win_row),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  // Record every window consumed and every frame_done pulse.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      wq.push_back(win_data);
      rq.push_back(win_row);
      cq.push_back(win_col);
    end
    if (frame_done) fd_cnt++;
  end

  task automatic send_px(input logic [7:0] v, input logic sof);
    int n;
    logic acc;
    in_valid = 1'b1; in_data = v; in_sof = sof; n = 0; acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clock); acc = in_ready;
      @(posedge clock); #1; n++;
    end
    in_valid = 1'b0; in_sof = 1'b0;
    checks++;
    if (!acc) begin errors++; $display("FAIL send_px_accept pixel=%0d got no accept, required accept within 50 cycles", v); end
  endtask

  task automatic send_frame();
    for (int i = 0; i < W*H; i++) send_px(8'(i), (i == 0));
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks += 6;
    if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready got %b required 1", in_ready); end
    if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
    if (win_data !== 72'd0)  begin errors++; $display("FAIL reset_win_data got %h required 0", win_data); end
    if (win_col !== 2'd0)    begin errors++; $display("FAIL reset_win_col got %0d required 0", win_col); end
    if (win_row !== 2'd0)    begin errors++; $display("FAIL reset_win_row got %0d required 0", win_row); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b required 0", frame_done); end
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_idle();
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      checks += 3;
      if (out_valid !== 1'b0)  begin errors++; $display("FAIL idle_out_valid cyc=%0d got %b required 0", k, out_valid); end
      if (frame_done !== 1'b0) begin errors++; $display("FAIL idle_frame_done cyc=%0d got %b required 0", k, frame_done); end
      if (in_ready !== 1'b1)   begin errors++; $display("FAIL idle_in_ready cyc=%0d got %b required 1", k, in_ready); end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_full_frame();
    int wb, fb;
    wb = wq.size(); fb = fd_cnt; out_ready = 1'b1;
    for (int i = 0; i < W*H; i++) begin
      send_px(8'(i), (i == 0));
      if (i == 9) begin
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL full_no_early_window got %b required 0", out_valid); end
      end
      if (i == 10) begin
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL full_first_latency got %b required 1", out_valid); end
        if (win_data !== exp_win[0] || win_row !== 2'd2 || win_col !== 2'd2) begin
          errors++; $display("FAIL full_first_window got %h r%0d c%0d required %h r2 c2", win_data, win_row, win_col, exp_win[0]);
        end
      end
      if (i == 14) begin
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL full_frame_done_early got %b required 0", frame_done); end
      end
      if (i == 15) begin
        checks++;
        if (frame_done !== 1'b1) begin errors++; $display("FAIL full_frame_done_pulse got %b required 1", frame_done); end
      end
    end
    @(posedge clock); #1;
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL full_frame_done_width got %b required 0", frame_done); end
    repeat (3) @(posedge clock);
    #1;
    checks += 2;
    if (wq.size() - wb !== 4) begin errors++; $display("FAIL full_window_count got %0d required 4", wq.size() - wb); end
    if (fd_cnt - fb !== 1)    begin errors++; $display("FAIL full_frame_done_count got %0d required 1", fd_cnt - fb); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wq.size() <= wb + k) begin errors++; $display("FAIL full_win%0d got none required %h", k, exp_win[k]); end
      else if (wq[wb+k] !== exp_win[k] || rq[wb+k] !== exp_row[k] || cq[wb+k] !== exp_col[k]) begin
        errors++; $display("FAIL full_win%0d got %h r%0d c%0d required %h r%0d c%0d", k, wq[wb+k], rq[wb+k], cq[wb+k], exp_win[k], exp_row[k], exp_col[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int wb;
    wb = wq.size(); out_ready = 1'b1;
    for (int i = 0; i <= 10; i++) send_px(8'(i), (i == 0));
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'd11; in_sof = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks += 3;
      if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp_in_ready cyc=%0d got %b required 0", k, in_ready); end
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc=%0d got %b required 1", k, out_valid); end
      if (win_data !== exp_win[0] || win_col !== 2'd2 || win_row !== 2'd2) begin
        errors++; $display("FAIL bp_hold cyc=%0d got %h r%0d c%0d required %h r2 c2", k, win_data, win_row, win_col, exp_win[0]);
      end
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    for (int i = 11; i < W*H; i++) send_px(8'(i), 1'b0);
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (wq.size() - wb !== 4) begin errors++; $display("FAIL bp_window_count got %0d required 4", wq.size() - wb); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wq.size() <= wb + k) begin errors++; $display("FAIL bp_win%0d got none required %h", k, exp_win[k]); end
      else if (wq[wb+k] !== exp_win[k] || rq[wb+k] !== exp_row[k] || cq[wb+k] !== exp_col[k]) begin
        errors++; $display("FAIL bp_win%0d got %h r%0d c%0d required %h r%0d c%0d", k, wq[wb+k], rq[wb+k], cq[wb+k], exp_win[k], exp_row[k], exp_col[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < W*H; i++) begin
      send_px(8'(i), (i == 0));
      if (i == 10) begin
        checks++;
        if (out_valid !== 1'b1 || win_col !== 2'd2) begin errors++; $display("FAIL b2b_first got v%b c%0d required v1 c2", out_valid, win_col); end
      end
      if (i == 11) begin
        checks++;
        if (out_valid !== 1'b1 || win_col !== 2'd3 || win_data !== exp_win[1]) begin
          errors++; $display("FAIL b2b_second got v%b c%0d %h required v1 c3 %h", out_valid, win_col, win_data, exp_win[1]);
        end
      end
    end
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic test_mid_sof();
    int wb, fb;
    wb = wq.size(); fb = fd_cnt; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) send_px(8'(i), (i == 0));
    send_frame();
    repeat (3) @(posedge clock);
    #1;
    checks += 2;
    if (fd_cnt - fb !== 1)    begin errors++; $display("FAIL sof_frame_done_count got %0d required 1", fd_cnt - fb); end
    if (wq.size() - wb !== 4) begin errors++; $display("FAIL sof_window_count got %0d required 4", wq.size() - wb); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wq.size() <= wb + k) begin errors++; $display("FAIL sof_win%0d got none required %h", k, exp_win[k]); end
      else if (wq[wb+k] !== exp_win[k] || rq[wb+k] !== exp_row[k] || cq[wb+k] !== exp_col[k]) begin
        errors++; $display("FAIL sof_win%0d got %h r%0d c%0d required %h r%0d c%0d", k, wq[wb+k], rq[wb+k], cq[wb+k], exp_win[k], exp_row[k], exp_col[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int wb, fb;
    out_ready = 1'b1;
    for (int i = 0; i <= 10; i++) send_px(8'(i), (i == 0));
    #2 reset_n = 1'b0;
    #1;
    checks += 6;
    if (out_valid !== 1'b0)  begin errors++; $display("FAIL rstmid_out_valid got %b required 0", out_valid); end
    if (in_ready !== 1'b1)   begin errors++; $display("FAIL rstmid_in_ready got %b required 1", in_ready); end
    if (win_data !== 72'd0)  begin errors++; $display("FAIL rstmid_win_data got %h required 0", win_data); end
    if (win_col !== 2'd0)    begin errors++; $display("FAIL rstmid_win_col got %0d required 0", win_col); end
    if (win_row !== 2'd0)    begin errors++; $display("FAIL rstmid_win_row got %0d required 0", win_row); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL rstmid_frame_done got %b required 0", frame_done); end
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    wb = wq.size(); fb = fd_cnt;
    send_frame();
    repeat (3) @(posedge clock);
    #1;
    checks += 2;
    if (fd_cnt - fb !== 1)    begin errors++; $display("FAIL rstmid_frame_done_count got %0d required 1", fd_cnt - fb); end
    if (wq.size() - wb !== 4) begin errors++; $display("FAIL rstmid_window_count got %0d required 4", wq.size() - wb); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wq.size() <= wb + k) begin errors++; $display("FAIL rstmid_win%0d got none required %h", k, exp_win[k]); end
      else if (wq[wb+k] !== exp_win[k] || rq[wb+k] !== exp_row[k] || cq[wb+k] !== exp_col[k]) begin
        errors++; $display("FAIL rstmid_win%0d got %h r%0d c%0d required %h r%0d c%0d", k, wq[wb+k], rq[wb+k], cq[wb+k], exp_win[k], exp_row[k], exp_col[k]);
      end
    end
  endtask

  initial begin
    // Element (r,c) sits at bits [8*(3r+c) +: 8], so the last listed byte is (0,0).
    exp_win[0] = {8'd10, 8'd9,  8'd8,  8'd6,  8'd5,  8'd4,  8'd2, 8'd1, 8'd0};
    exp_win[1] = {8'd11, 8'd10, 8'd9,  8'd7,  8'd6,  8'd5,  8'd3, 8'd2, 8'd1};
    exp_win[2] = {8'd14, 8'd13, 8'd12, 8'd10, 8'd9,  8'd8,  8'd6, 8'd5, 8'd4};
    exp_win[3] = {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9,  8'd7, 8'd6, 8'd5};
    exp_row[0] = 2'd2; exp_col[0] = 2'd2;
    exp_row[1] = 2'd2; exp_col[1] = 2'd3;
    exp_row[2] = 2'd3; exp_col[2] = 2'd2;
    exp_row[3] = 2'd3; exp_col[3] = 2'd3;

    test_reset();
    test_idle();
    test_full_frame();
    test_backpressure();
    test_back_to_back();
    test_mid_sof();
    test_reset_mid();
    test_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
